// File: rtl/uart_tx_buffered.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_buffered
// Purpose  : Buffered 8N1 UART transmitter with 16x oversampling baud ticks.
//            Bytes written by the datapath are queued in an internal FIFO and
//            sent onto the serial line one frame per byte.
// Ports    : clk      - system clock, rising edge
//            reset    - synchronous active-high reset
//            wr_uart  - write strobe (accepted when tx_full=0)
//            w_data   - byte to queue
//            tx_full  - FIFO holds 2**ADDR_W entries
//            tx_empty - FIFO holds no entries
//            tx_busy  - a frame is on the line
//            tx       - serial output, idle high
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_buffered #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int DVSR    = 163,
    parameter int DVSR_W  = 8,
    parameter int ADDR_W  = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wr_uart,
    input  logic [DBIT-1:0] w_data,
    output logic            tx_full,
    output logic            tx_empty,
    output logic            tx_busy,
    output logic            tx
);

    localparam int c_DEPTH = 2 ** ADDR_W;
    localparam int c_N_W   = (DBIT > 1) ? $clog2(DBIT) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Baud tick generator (free running, never re-phased per frame)
    // ------------------------------------------------------------------
    logic [DVSR_W-1:0] baud_q, baud_d;
    logic              s_tick;

    always_comb begin
        s_tick = (baud_q == DVSR_W'(DVSR - 1));
        baud_d = s_tick ? '0 : baud_q + 1'b1;
    end

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [DBIT-1:0]   mem_q [c_DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              push;
    logic              pop;

    // A write while full is dropped even if the FSM pops in the same cycle.
    assign push = wr_uart && !full_q;

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // Flags are registered from the post-edge count.
        full_d  = (count_d == (ADDR_W+1)'(c_DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= w_data;
        end
    end

    // ------------------------------------------------------------------
    // Transmit FSM
    // ------------------------------------------------------------------
    state_t            state_q, state_d;
    logic [3:0]        s_q, s_d;
    logic [c_N_W-1:0]  n_q, n_d;
    logic [DBIT-1:0]   b_q, b_d;
    logic              tx_q, tx_d;

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty_q) begin
                    pop     = 1'b1;
                    b_d     = mem_q[rd_ptr_q];
                    s_d     = 4'd0;
                    state_d = START;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_q == 4'd15) begin
                        s_d     = 4'd0;
                        n_d     = '0;
                        state_d = DATA;
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_q == 4'd15) begin
                        s_d = 4'd0;
                        b_d = b_q >> 1;
                        if (n_q == c_N_W'(DBIT - 1)) begin
                            state_d = STOP;
                        end else begin
                            n_d = n_q + 1'b1;
                        end
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            default: begin // STOP
                if (s_tick) begin
                    if (s_q == 4'(SB_TICK - 1)) begin
                        state_d = IDLE;
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
        endcase

        // The line level is registered from the next state, so tx changes
        // on the same edge as the state and never glitches.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = b_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            baud_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            state_q  <= IDLE;
            s_q      <= 4'd0;
            n_q      <= '0;
            b_q      <= '0;
            tx_q     <= 1'b1;
        end else begin
            baud_q   <= baud_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            state_q  <= state_d;
            s_q      <= s_d;
            n_q      <= n_d;
            b_q      <= b_d;
            tx_q     <= tx_d;
        end
    end

    assign tx       = tx_q;
    assign tx_full  = full_q;
    assign tx_empty = empty_q;
    assign tx_busy  = (state_q != IDLE);

endmodule
`default_nettype wire
